// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with a small output FIFO.
//   clk, rst_n : system clock, asynchronous active-low reset
//   rx         : raw serial line (asynchronous, idle high)
//   data/valid : FIFO head byte and non-empty flag
//   ready      : consumer pops the head when valid && ready
//   frame_err  : one-cycle pulse, stop bit sampled low
//   overrun    : one-cycle pulse, good byte dropped because FIFO full
module uart_rx_fifo #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CW           = $clog2(CLKS_PER_BIT);
    localparam int unsigned AW           = $clog2(FIFO_DEPTH);
    localparam int unsigned OW           = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t          state;
    logic            rx_meta;
    logic            rxs;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [OW-1:0]   count;

    logic            cnt_last;
    logic            push_req;
    logic            full;
    logic            do_pop;
    logic            do_push;
    logic            drop;
    logic [OW-1:0]   count_nxt;
    logic [7:0]      data_nxt;

    // Two-flop synchroniser; idles high so reset never looks like a start bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // FIFO control: push/pop arbitration and next head byte
    always_comb begin
        cnt_last  = (cnt == CW'(CLKS_PER_BIT - 1));
        push_req  = (state == S_STOP) && cnt_last && rxs;
        full      = (count == OW'(FIFO_DEPTH));
        do_pop    = valid && ready;
        do_push   = push_req && (!full || do_pop);
        drop      = push_req && full && !do_pop;
        count_nxt = count + OW'(do_push) - OW'(do_pop);

        data_nxt = data;
        if (do_pop) begin
            // Next head is the entry behind the current one, or the byte
            // arriving now if the FIFO held only one entry
            if (count > OW'(1)) begin
                data_nxt = mem[rd_ptr + AW'(1)];
            end else if (do_push) begin
                data_nxt = shift;
            end
        end else if ((count == '0) && do_push) begin
            data_nxt = shift;
        end
    end

    // Receive FSM; baud counter clears whenever the state changes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            cnt       <= cnt_last ? '0 : cnt + CW'(1);
            case (state)
                S_IDLE: begin
                    if (!rxs) begin
                        state <= S_START;
                        cnt   <= '0;
                    end
                end
                S_START: begin
                    if (cnt == CW'(HALF_BIT - 1)) begin
                        state   <= rxs ? S_IDLE : S_DATA;
                        cnt     <= '0;
                        bit_cnt <= '0;
                    end
                end
                S_DATA: begin
                    if (cnt_last) begin
                        shift   <= {rxs, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    if (cnt_last) begin
                        if (rxs) begin
                            state <= S_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    if (rxs) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // FIFO storage; contents need no reset since count gates validity
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= shift;
        end
    end

    // FIFO pointers, occupancy and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            data    <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count   <= count_nxt;
            data    <= data_nxt;
            valid   <= (count_nxt != '0);
            overrun <= drop;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed and randomized checks of uart_rx_fifo against a
// byte-queue reference model and event-cycle predictions.
module tb_uart_rx_fifo;

    localparam int unsigned CLK_FREQ  = 1000000;
    localparam int unsigned BAUD      = 100000;
    localparam int unsigned DEPTH     = 4;
    localparam int          CPB       = 10;
    // Cycles from the first low rx drive to the edge that acts on the stop
    // sample: 2 synchroniser flops + 1 IDLE detection edge, then T0-relative
    // stop sample at CPB/2 + 9*CPB - 1, acted on at the following edge.
    localparam int          STOP_EDGE = 3 + CPB / 2 + 9 * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       ready = 1'b1;
    logic       frame_err;
    logic       overrun;

    int tests_run = 0;
    int tests_failed = 0;
    int cycle = 0;

    logic [7:0] exp_q[$];
    int  pop_cnt = 0;
    int  fe_cnt = 0;
    int  ov_cnt = 0;
    int  fe_cyc = -1;
    int  ov_cyc = -1;
    int  vrise_cyc = -1;
    logic prev_valid = 1'b0;
    bit  rand_ready = 1'b0;

    uart_rx_fifo #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .data     (data),
        .valid    (valid),
        .ready    (ready),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: pops are scored against the reference queue; pulses are logged
    always @(negedge clk) begin
        logic [31:0] expv;
        if (rst_n) begin
            if (valid && !prev_valid) vrise_cyc = cycle;
            if (frame_err) begin fe_cnt++; fe_cyc = cycle; end
            if (overrun) begin ov_cnt++; ov_cyc = cycle; end
            if (frame_err || overrun) check("pulse_exclusive", 32'(frame_err & overrun), 32'd0);
            if (valid && ready) begin
                expv = (exp_q.size() > 0) ? {24'h0, exp_q.pop_front()} : 32'hDEAD;
                pop_cnt++;
                check("pop_data", {24'h0, data}, expv);
            end
        end
        prev_valid = valid;
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Drive one 8N1 frame; optionally raise ready only for the stop-sample cycle
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input bit pulse_rdy, output int t0);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        t0 = cycle;
        for (int n = 0; n < 10 * CPB; n++) begin
            rx = fr[n / CPB];
            if (pulse_rdy) begin
                if (n == STOP_EDGE - 1) ready = 1'b1;
                else if (n == STOP_EDGE) ready = 1'b0;
            end
            tick();
        end
        rx = 1'b1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && valid; i++) tick();
        check(tag, 32'(valid), 32'd0);
    endtask

    initial begin
        int t0;
        int t5;
        int p0;
        int f0;
        int o0;
        int v0;
        logic [7:0] b;

        // Reset with the line toggling
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rx = 1'(i & 1);
            tick();
        end
        rx = 1'b1;
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_data", {24'h0, data}, 32'h0);
        rst_n = 1'b1;
        ticks(5);
        check("post_rst_valid", 32'(valid), 32'd0);
        check("post_rst_ferr", 32'(fe_cnt), 32'd0);
        check("post_rst_ovr", 32'(ov_cnt), 32'd0);
        check("post_rst_data", {24'h0, data}, 32'h0);

        // Single frame 0xA5 with ready held high
        ready = 1'b1;
        p0 = pop_cnt;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0, t0);
        check("a5_valid_rise_cycle", 32'(vrise_cyc), 32'(t0 + STOP_EDGE));
        check("a5_valid_dropped", 32'(valid), 32'd0);
        check("a5_pops", 32'(pop_cnt - p0), 32'd1);

        // Short glitch is rejected
        f0 = fe_cnt; v0 = vrise_cyc;
        rx = 1'b0;
        ticks(3);
        rx = 1'b1;
        ticks(30);
        check("glitch_no_ferr", 32'(fe_cnt - f0), 32'd0);
        check("glitch_no_valid", 32'(vrise_cyc), 32'(v0));

        // Framing error followed by a held-low line: exactly one pulse
        f0 = fe_cnt; v0 = vrise_cyc;
        send_frame(8'h3C, 1'b0, 1'b0, t0);
        rx = 1'b0;
        ticks(50);
        rx = 1'b1;
        ticks(30);
        check("ferr_count", 32'(fe_cnt - f0), 32'd1);
        check("ferr_cycle", 32'(fe_cyc), 32'(t0 + STOP_EDGE));
        check("ferr_no_push", 32'(vrise_cyc), 32'(v0));
        p0 = pop_cnt;
        exp_q.push_back(8'h42);
        send_frame(8'h42, 1'b1, 1'b0, t0);
        ticks(3);
        check("after_ferr_pop", 32'(pop_cnt - p0), 32'd1);

        // Overrun: fill with ready low, fifth byte is dropped
        ready = 1'b0;
        o0 = ov_cnt;
        for (int k = 1; k <= 4; k++) exp_q.push_back(8'(k));
        for (int k = 1; k <= 5; k++) begin
            send_frame(8'(k), 1'b1, 1'b0, t0);
            if (k == 5) t5 = t0;
        end
        check("ovr_count", 32'(ov_cnt - o0), 32'd1);
        check("ovr_cycle", 32'(ov_cyc), 32'(t5 + STOP_EDGE));
        check("ovr_head", {24'h0, data}, 32'h01);
        ticks(20);
        check("ovr_head_held", {24'h0, data}, 32'h01);
        check("ovr_valid_held", 32'(valid), 32'd1);
        p0 = pop_cnt;
        ready = 1'b1;
        drain("ovr_drain_valid");
        check("ovr_pops", 32'(pop_cnt - p0), 32'd4);
        check("ovr_queue_empty", 32'(exp_q.size()), 32'd0);

        // Push and pop in the same cycle while full
        ready = 1'b0;
        o0 = ov_cnt;
        for (int k = 1; k <= 4; k++) exp_q.push_back(8'(k));
        exp_q.push_back(8'h66);
        for (int k = 1; k <= 4; k++) send_frame(8'(k), 1'b1, 1'b0, t0);
        p0 = pop_cnt;
        send_frame(8'h66, 1'b1, 1'b1, t0);
        check("full_pp_no_ovr", 32'(ov_cnt - o0), 32'd0);
        check("full_pp_one_pop", 32'(pop_cnt - p0), 32'd1);
        check("full_pp_head", {24'h0, data}, 32'h02);
        ready = 1'b1;
        drain("full_pp_drain_valid");
        check("full_pp_pops", 32'(pop_cnt - p0), 32'd5);
        check("full_pp_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset mid-frame discards partial byte and FIFO contents
        ready = 1'b0;
        send_frame(8'h77, 1'b1, 1'b0, t0);
        check("mid_rst_prefill", 32'(valid), 32'd1);
        rx = 1'b0;
        ticks(30);
        rst_n = 1'b0;
        ticks(3);
        rx = 1'b1;
        check("mid_rst_valid", 32'(valid), 32'd0);
        check("mid_rst_data", {24'h0, data}, 32'h0);
        f0 = fe_cnt; v0 = vrise_cyc;
        rst_n = 1'b1;
        ticks(150);
        check("mid_rst_no_valid", 32'(valid), 32'd0);
        check("mid_rst_no_ferr", 32'(fe_cnt - f0), 32'd0);

        // Random bytes, random gaps, random consumer stalls
        o0 = ov_cnt; f0 = fe_cnt; p0 = pop_cnt;
        rand_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_frame(b, 1'b1, 1'b0, t0);
            ticks(int'($urandom_range(0, 20)));
        end
        rand_ready = 1'b0;
        tick();
        ready = 1'b1;
        drain("rand_drain_valid");
        check("rand_pops", 32'(pop_cnt - p0), 32'd20);
        check("rand_queue_empty", 32'(exp_q.size()), 32'd0);
        check("rand_no_ovr", 32'(ov_cnt - o0), 32'd0);
        check("rand_no_ferr", 32'(fe_cnt - f0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
